// File: rtl/ros2rapper_tx_scheduler.sv
// ros2rapper_tx_scheduler: picks an eligible RTPS submessage kind, starts the packet generator,
// waits for completion (with optional timeout), then re-arms the counters. ROS2_TX_SCHED_RR_EN selects round-robin.
module ros2rapper_tx_scheduler #(
    parameter int NUM_KINDS    = 8,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_remote_found,
    input  logic       i_pub_an_req,
    input  logic       i_sub_an_req,
    input  logic       i_app_data_rdy,
    input  logic       i_cnt_interval_elapsed,
    input  logic       i_cnt_spdp_wr_elapsed,
    input  logic       i_cnt_sedp_pub_wr_elapsed,
    input  logic       i_cnt_sedp_sub_wr_elapsed,
    input  logic       i_cnt_sedp_pub_hb_elapsed,
    input  logic       i_cnt_sedp_sub_hb_elapsed,
    input  logic       i_cnt_sedp_pub_an_elapsed,
    input  logic       i_cnt_sedp_sub_an_elapsed,
    input  logic       i_cnt_app_wr_elapsed,
    output logic       o_cnt_interval_set,
    output logic       o_cnt_spdp_wr_set,
    output logic       o_cnt_sedp_pub_wr_set,
    output logic       o_cnt_sedp_sub_wr_set,
    output logic       o_cnt_sedp_pub_hb_set,
    output logic       o_cnt_sedp_sub_hb_set,
    output logic       o_cnt_sedp_pub_an_set,
    output logic       o_cnt_sedp_sub_an_set,
    output logic       o_cnt_app_wr_set,
    output logic       o_tx_start,
    output logic [2:0] o_tx_kind,
    input  logic       i_tx_ready,
    input  logic       i_tx_done,
    output logic       o_busy,
    output logic       o_timeout
);
    localparam int CW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, REARM} state_t;

    state_t               state_q, state_d;
    logic [2:0]           kind_q, kind_d, ptr, sel;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_KINDS-1:0] elapsed, elig, set_vec;

    assign elapsed = {i_cnt_app_wr_elapsed, i_cnt_sedp_sub_an_elapsed, i_cnt_sedp_pub_an_elapsed,
                      i_cnt_sedp_sub_hb_elapsed, i_cnt_sedp_pub_hb_elapsed, i_cnt_sedp_sub_wr_elapsed,
                      i_cnt_sedp_pub_wr_elapsed, i_cnt_spdp_wr_elapsed};
    assign elig = elapsed & {i_remote_found & i_app_data_rdy, i_remote_found & i_sub_an_req,
                             i_remote_found & i_pub_an_req, {4{i_remote_found}}, 1'b1};

`ifdef ROS2_TX_SCHED_RR_EN
    logic [2:0] ptr_q;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) ptr_q <= '0;
        else if (state_q == REARM) ptr_q <= kind_q + 3'd1;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // Scan from the far end so the eligible kind nearest the pointer wins.
    always_comb begin
        sel = '0;
        for (int k = NUM_KINDS - 1; k >= 0; k--)
            if (elig[ptr + 3'(k)]) sel = ptr + 3'(k);
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        o_timeout = 1'b0;
        case (state_q)
            IDLE:
                if (i_enable && i_cnt_interval_elapsed && |elig) begin
                    kind_d  = sel;
                    state_d = START;
                end
            START:
                if (i_tx_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            WAIT:
                if (i_tx_done) state_d = REARM;
                else if (DONE_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    o_timeout = 1'b1;
                    state_d   = REARM;
                end else cnt_d = cnt_q + CW'(1);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state_q <= IDLE;
            kind_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end

    assign o_tx_start         = state_q == START;
    assign o_tx_kind          = kind_q;
    assign o_busy             = state_q != IDLE;
    assign o_cnt_interval_set = state_q == REARM;
    assign set_vec            = (state_q == REARM) ? {{(NUM_KINDS-1){1'b0}}, 1'b1} << kind_q : '0;
    assign o_cnt_spdp_wr_set     = set_vec[0];
    assign o_cnt_sedp_pub_wr_set = set_vec[1];
    assign o_cnt_sedp_sub_wr_set = set_vec[2];
    assign o_cnt_sedp_pub_hb_set = set_vec[3];
    assign o_cnt_sedp_sub_hb_set = set_vec[4];
    assign o_cnt_sedp_pub_an_set = set_vec[5];
    assign o_cnt_sedp_sub_an_set = set_vec[6];
    assign o_cnt_app_wr_set      = set_vec[7];
endmodule

// File: tb/tb_ros2rapper_tx_scheduler.sv
// tb_ros2rapper_tx_scheduler: directed checks of selection, handshake, timeout, re-arm and reset.
module tb_ros2rapper_tx_scheduler;
    logic       clk = 0, rst_n = 0, en = 0, remote = 0, pub_an = 0, sub_an = 0, app_rdy = 0;
    logic       interval = 1, ready = 0, done = 0;
    logic [7:0] el = '0;
    logic       int_set, start, busy, to;
    logic [2:0] kind;
    logic [7:0] sets, exp_set;
    logic [2:0] exp_order [4];
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    ros2rapper_tx_scheduler #(.NUM_KINDS(8), .DONE_TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_remote_found(remote),
        .i_pub_an_req(pub_an), .i_sub_an_req(sub_an), .i_app_data_rdy(app_rdy),
        .i_cnt_interval_elapsed(interval),
        .i_cnt_spdp_wr_elapsed(el[0]), .i_cnt_sedp_pub_wr_elapsed(el[1]),
        .i_cnt_sedp_sub_wr_elapsed(el[2]), .i_cnt_sedp_pub_hb_elapsed(el[3]),
        .i_cnt_sedp_sub_hb_elapsed(el[4]), .i_cnt_sedp_pub_an_elapsed(el[5]),
        .i_cnt_sedp_sub_an_elapsed(el[6]), .i_cnt_app_wr_elapsed(el[7]),
        .o_cnt_interval_set(int_set),
        .o_cnt_spdp_wr_set(sets[0]), .o_cnt_sedp_pub_wr_set(sets[1]),
        .o_cnt_sedp_sub_wr_set(sets[2]), .o_cnt_sedp_pub_hb_set(sets[3]),
        .o_cnt_sedp_sub_hb_set(sets[4]), .o_cnt_sedp_pub_an_set(sets[5]),
        .o_cnt_sedp_sub_an_set(sets[6]), .o_cnt_app_wr_set(sets[7]),
        .o_tx_start(start), .o_tx_kind(kind), .i_tx_ready(ready), .i_tx_done(done),
        .o_busy(busy), .o_timeout(to)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef ROS2_TX_SCHED_RR_EN
        exp_order = '{3'd0, 3'd3, 3'd7, 3'd0};
`else
        exp_order = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
        // reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_kind", kind, 0);
        chk("rst_sets", {to, int_set, sets}, 0);
        // SPDP with no remote: only kind 0 eligible
        el = 8'hFF; en = 1; rst_n = 1;
        chk("idle_no_start", start, 0);
        tick();
        chk("spdp_start", start, 1);
        chk("spdp_kind", kind, 0);
        tick();
        chk("start_hold", start, 1);
        ready = 1; tick(); ready = 0;
        chk("wait_start_low", start, 0);
        chk("wait_busy", busy, 1);
        done = 1; tick(); done = 0; en = 0;
        chk("rearm_sets", sets, 8'h01);
        chk("rearm_int", int_set, 1);
        tick();
        chk("post_rearm_sets", {int_set, sets}, 0);
        chk("post_rearm_idle", busy, 0);
        // SEDP_SUB_AN gated by its request
        el = 8'h40; remote = 1; en = 1;
        tick(); tick(); tick();
        chk("an_gated", busy, 0);
        sub_an = 1; tick();
        chk("an_start", start, 1);
        chk("an_kind", kind, 6);
        // stall in START, drop enable and eligibility
        for (int i = 0; i < 10; i++) begin
            if (i == 0) el = 8'h00;
            if (i == 3) en = 0;
            chk("stall_start", start, 1);
            chk("stall_kind", kind, 6);
            tick();
        end
        ready = 1; tick(); ready = 0;
        chk("to_wait", {busy, start}, 2'b10);
        // timeout after 16 waiting cycles
        for (int i = 0; i < 15; i++) begin
            chk("to_early", to, 0);
            tick();
        end
        chk("to_pulse", to, 1);
        tick();
        chk("to_sets", sets, 8'h40);
        chk("to_int", int_set, 1);
        chk("to_once", to, 0);
        tick();
        chk("to_idle", busy, 0);
        // done coincident with expiry wins
        el = 8'h01; en = 1; tick(); en = 0;
        chk("dt_kind", {start, kind}, 4'b1000);
        ready = 1; tick(); ready = 0;
        repeat (15) tick();
        done = 1; #1;
        chk("dt_no_to", to, 0);
        tick(); done = 0;
        chk("dt_sets", sets, 8'h01);
        chk("dt_to_after", to, 0);
        tick();
        // selection order with kinds 0, 3, 7 eligible
        rst_n = 0; tick(); rst_n = 1;
        el = 8'h89; app_rdy = 1; remote = 1; en = 1;
        for (int g = 0; g < 4; g++) begin
            int n = 0;
            while (!start && n < 4) begin tick(); n++; end
            chk("ord_start", start, 1);
            chk("ord_kind", kind, exp_order[g]);
            ready = 1; tick(); ready = 0;
            done = 1; tick(); done = 0;
            exp_set = 8'h01 << exp_order[g];
            chk("ord_sets", sets, exp_set);
            tick();
        end
        // async reset mid-WAIT
        tick(); ready = 1; tick(); ready = 0;
        chk("ar_wait", {busy, start}, 2'b10);
        rst_n = 0; #1;
        chk("ar_busy", busy, 0);
        chk("ar_start", start, 0);
        chk("ar_sets", {int_set, sets}, 0);
        tick(); rst_n = 1; tick();
        chk("ar_no_set", {int_set, sets}, 0);
        chk("ar_restart", {start, kind}, 4'b1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ros2rapper_tx_scheduler.md
Name: ros2rapper_tx_scheduler

Overview:
- Consumer side of the TX period counters. Watches the nine `*_elapsed` flags and per-kind eligibility inputs.
- Picks one RTPS submessage kind and hands it to the packet generator through a valid/ready start handshake.
- Waits for generator completion, then pulses the matching counter `set` inputs to re-arm the period and the inter-packet interval.
- Sits between the TX counters and the TX packet generator inside ros2rapper.

Parameters:
- NUM_KINDS, 8, number of schedulable kinds; fixed encoding width 3 bits.
- DONE_TIMEOUT, 4096, i_clk cycles to wait for i_tx_done before abandoning a transmission; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  scheduler enable; low blocks new starts, in-flight transfer still completes
- i_remote_found  in  1  remote participant discovered; gates all SEDP kinds and APP_WR
- i_pub_an_req  in  1  pending ACKNACK for SEDP publication reader
- i_sub_an_req  in  1  pending ACKNACK for SEDP subscription reader
- i_app_data_rdy  in  1  application payload available
- i_cnt_interval_elapsed  in  1  inter-packet interval expired
- i_cnt_spdp_wr_elapsed .. i_cnt_app_wr_elapsed  in  1 each (8 ports)  per-kind period expired
- o_cnt_interval_set  out  1  one-cycle re-arm pulse for the interval counter
- o_cnt_spdp_wr_set .. o_cnt_app_wr_set  out  1 each (8 ports)  one-cycle per-kind re-arm pulses
- o_tx_start  out  1  start request valid
- o_tx_kind  out  3  kind: 0 SPDP_WR, 1 SEDP_PUB_WR, 2 SEDP_SUB_WR, 3 SEDP_PUB_HB, 4 SEDP_SUB_HB, 5 SEDP_PUB_AN, 6 SEDP_SUB_AN, 7 APP_WR
- i_tx_ready  in  1  generator accepts start
- i_tx_done  in  1  one-cycle pulse: generator finished the packet
- o_busy  out  1  high in any state other than IDLE
- o_timeout  out  1  one-cycle pulse when DONE_TIMEOUT expires

Behaviour:
- Reset: all outputs 0; FSM in IDLE; o_tx_kind = 0; priority pointer = 0; timeout counter = 0.
- Eligibility per kind:
  - SPDP_WR: elapsed flag only.
  - SEDP_*_WR and SEDP_*_HB: elapsed & i_remote_found.
  - SEDP_PUB_AN: elapsed & i_remote_found & i_pub_an_req.
  - SEDP_SUB_AN: elapsed & i_remote_found & i_sub_an_req.
  - APP_WR: elapsed & i_remote_found & i_app_data_rdy.
- IDLE: when i_enable & i_cnt_interval_elapsed & any kind eligible, register the selected kind into o_tx_kind and go to START. Default selection is fixed priority, lowest index wins. o_tx_start rises on the clock edge after the condition is sampled (1-cycle latency).
- START: o_tx_start = 1 and o_tx_kind held stable until i_tx_ready is sampled high, then go to WAIT. i_enable falling in START does not withdraw the request.
- WAIT: hold o_tx_kind and count cycles.
  - On i_tx_done, go to REARM.
  - If DONE_TIMEOUT != 0 and the count reaches DONE_TIMEOUT-1 without done, pulse o_timeout and go to REARM.
  - A done arriving on the same cycle as timeout expiry counts as done: no o_timeout.
- REARM: for exactly one cycle pulse o_cnt_interval_set and the set output of the latched kind; all other set outputs stay 0. Return to IDLE. IDLE does not evaluate a new start in the same cycle as REARM.
- Consequence: minimum spacing from done to the next o_tx_start is 3 cycles. The counters drive elapsed low after set, so the same kind is not reselected early.
- i_tx_done outside WAIT is ignored. i_tx_ready outside START is ignored.
- Eligibility inputs change freely; they are sampled only in IDLE.
- Asynchronous reset mid-transfer: return to IDLE immediately, outputs 0, no set pulses. The counters are reset on the same net.

Optional Feature:
- Macro ROS2_TX_SCHED_RR_EN.
- Defined: round-robin selection. A 3-bit pointer holds the last-granted kind + 1 (mod 8), updated in REARM. Selection searches eligible kinds starting from the pointer, wrapping 7 -> 0.
- Undefined: fixed priority, lowest index wins; the pointer logic is absent.

Test Plan:
- Release reset, all elapsed = 1, i_remote_found = 0, i_enable = 1 -> o_tx_start with kind 0 one cycle after IDLE sample. Ready high -> WAIT. Done -> one-cycle o_cnt_spdp_wr_set and o_cnt_interval_set, no other set pulses.
- i_remote_found = 1, only SEDP_SUB_AN elapsed, i_sub_an_req = 0 -> no start. Raise i_sub_an_req -> start with kind 6.
- Hold i_tx_ready = 0 for 10 cycles in START -> o_tx_start and o_tx_kind stable throughout. Drop i_enable during START -> request remains.
- DONE_TIMEOUT = 16, never assert done -> o_timeout pulse 16 cycles after ready accept, then set pulses for the latched kind. Done on the expiry cycle -> no o_timeout.
- With ROS2_TX_SCHED_RR_EN, kinds 0, 3 and 7 permanently eligible, interval always elapsed -> grant order 0, 3, 7, 0. Without the macro -> 0, 0, 0.
- Assert i_rst_n low during WAIT -> o_busy = 0 and o_tx_start = 0 immediately. No set pulse after release. The first start after release selects kind 0.
